// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - state, tag, length types and header bytes for tx_resp_sched (TX_FRAME_EN)
package tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_LO  = 2'd1,
        SEND_HI  = 2'd2
`ifdef TX_FRAME_EN
        ,
        SEND_HDR = 2'd3
`endif
    } sched_state_t;

    typedef enum logic {
        TAG_RF  = 1'b0,
        TAG_ALU = 1'b1
    } src_tag_t;

    typedef enum logic {
        LEN_1 = 1'b0,
        LEN_2 = 1'b1
    } slot_len_t;

`ifdef TX_FRAME_EN
    localparam logic [7:0] HDR_RF  = 8'h52;
    localparam logic [7:0] HDR_ALU = 8'h41;
    localparam sched_state_t FIRST_STATE = SEND_HDR;
`else
    localparam sched_state_t FIRST_STATE = SEND_LO;
`endif

endpackage

// File: rtl/resp_slot.sv
// rtl/resp_slot.sv - one-entry response register (data, length, tag, full) with load and clear
module resp_slot
    import tx_sched_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] load_data,
    input  slot_len_t    load_len,
    input  src_tag_t     load_tag,
    output logic [W-1:0] data,
    output slot_len_t    len,
    output src_tag_t     tag,
    output logic         full
);

    // load wins over clear so a slot can be emptied and refilled in one cycle
    always_ff @(posedge CLK) begin
        if (!RST) begin
            data <= '0;
            len  <= LEN_1;
            tag  <= TAG_RF;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            len  <= load_len;
            tag  <= load_tag;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/tx_resp_sched.sv
// rtl/tx_resp_sched.sv - splits RF/ALU responses into TX FIFO bytes; TX_FRAME_EN adds a header byte
module tx_resp_sched
    import tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    FIFO_FULL,
    output logic [DATA_WIDTH-1:0]   WR_DATA,
    output logic                    WR_INC,
    output logic                    BUSY,
    output logic                    DROP_ERR
);

    localparam int SW = 2 * DATA_WIDTH;

    sched_state_t state, state_nxt;

    logic          act_load, act_clear, pend_load, pend_clear, drop;
    logic [SW-1:0] act_ld_data, pend_ld_data, act_data, pend_data;
    slot_len_t     act_ld_len, pend_ld_len, act_len, pend_len;
    src_tag_t      act_ld_tag, pend_ld_tag, act_tag, pend_tag;
    logic          act_full, pend_full;

    logic          any_vld, two_vld, last_byte, done;
    logic [SW-1:0] rf_ext, in0_data;
    slot_len_t     in0_len;
    src_tag_t      in0_tag;

    // ALU wins the earlier slot when both sources fire together
    assign rf_ext   = {{DATA_WIDTH{1'b0}}, RF_RdData};
    assign any_vld  = ALU_OUT_VLD | RF_RdData_VLD;
    assign two_vld  = ALU_OUT_VLD & RF_RdData_VLD;
    assign in0_data = ALU_OUT_VLD ? ALU_OUT : rf_ext;
    assign in0_len  = ALU_OUT_VLD ? LEN_2 : LEN_1;
    assign in0_tag  = ALU_OUT_VLD ? TAG_ALU : TAG_RF;

    assign WR_INC    = RST & (state != IDLE) & ~FIFO_FULL;
    assign last_byte = (state == SEND_HI) || ((state == SEND_LO) && (act_len == LEN_1));
    assign done      = WR_INC & last_byte;
    assign BUSY      = act_full | pend_full;

    always_comb begin
        act_load     = 1'b0;
        act_clear    = 1'b0;
        pend_load    = 1'b0;
        pend_clear   = 1'b0;
        drop         = 1'b0;
        act_ld_data  = in0_data;
        act_ld_len   = in0_len;
        act_ld_tag   = in0_tag;
        pend_ld_data = in0_data;
        pend_ld_len  = in0_len;
        pend_ld_tag  = in0_tag;
        if (!act_full) begin
            act_load     = any_vld;
            pend_load    = two_vld;
            pend_ld_data = rf_ext;
            pend_ld_len  = LEN_1;
            pend_ld_tag  = TAG_RF;
        end else if (done) begin
            if (pend_full) begin
                act_load    = 1'b1;
                act_ld_data = pend_data;
                act_ld_len  = pend_len;
                act_ld_tag  = pend_tag;
                pend_clear  = 1'b1;
                pend_load   = any_vld;
                drop        = two_vld;
            end else begin
                act_load     = any_vld;
                act_clear    = ~any_vld;
                pend_load    = two_vld;
                pend_ld_data = rf_ext;
                pend_ld_len  = LEN_1;
                pend_ld_tag  = TAG_RF;
            end
        end else if (!pend_full) begin
            pend_load = any_vld;
            drop      = two_vld;
        end else begin
            drop = any_vld;
        end
    end

    resp_slot #(.W(SW)) u_active (
        .CLK       (CLK),
        .RST       (RST),
        .load      (act_load),
        .clear     (act_clear),
        .load_data (act_ld_data),
        .load_len  (act_ld_len),
        .load_tag  (act_ld_tag),
        .data      (act_data),
        .len       (act_len),
        .tag       (act_tag),
        .full      (act_full)
    );

    resp_slot #(.W(SW)) u_pending (
        .CLK       (CLK),
        .RST       (RST),
        .load      (pend_load),
        .clear     (pend_clear),
        .load_data (pend_ld_data),
        .load_len  (pend_ld_len),
        .load_tag  (pend_ld_tag),
        .data      (pend_data),
        .len       (pend_len),
        .tag       (pend_tag),
        .full      (pend_full)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= IDLE;
            DROP_ERR <= 1'b0;
        end else begin
            state    <= state_nxt;
            DROP_ERR <= drop;
        end
    end

    always_comb begin
        state_nxt = state;
        WR_DATA   = '0;
        case (state)
            IDLE:     if (any_vld) state_nxt = FIRST_STATE;
`ifdef TX_FRAME_EN
            SEND_HDR: if (WR_INC) state_nxt = SEND_LO;
`endif
            SEND_LO:  if (WR_INC) state_nxt = (act_len == LEN_2) ? SEND_HI : IDLE;
            SEND_HI:  if (WR_INC) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        // a queued or just-arrived response follows without an idle cycle
        if (done && (pend_full || any_vld))
            state_nxt = FIRST_STATE;

        if (RST) begin
            case (state)
                SEND_LO:  WR_DATA = act_data[DATA_WIDTH-1:0];
                SEND_HI:  WR_DATA = act_data[SW-1:DATA_WIDTH];
`ifdef TX_FRAME_EN
                SEND_HDR: WR_DATA = (act_tag == TAG_ALU) ? DATA_WIDTH'(HDR_ALU) : DATA_WIDTH'(HDR_RF);
`endif
                default:  WR_DATA = '0;
            endcase
        end
    end

`ifndef TX_FRAME_EN
    logic unused_act_tag;
    assign unused_act_tag = act_tag;
`endif

endmodule

// File: tb/tb_tx_resp_sched.sv
// tb/tb_tx_resp_sched.sv - queue-model scoreboard plus directed byte-sequence checks for tx_resp_sched
module tb_tx_resp_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RF_RdData = '0;
    logic        RF_RdData_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic [7:0]  WR_DATA;
    logic        WR_INC;
    logic        BUSY;
    logic        DROP_ERR;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drops = 0;
    int log_c[$];
    logic [7:0] log_b[$];

    tx_resp_sched #(.DATA_WIDTH(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .FIFO_FULL     (FIFO_FULL),
        .WR_DATA       (WR_DATA),
        .WR_INC        (WR_INC),
        .BUSY          (BUSY),
        .DROP_ERR      (DROP_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: at most two responses held (the one being sent plus one waiting)
    typedef struct packed {
        logic [23:0] bytes;
        logic [7:0]  n;
    } resp_t;

    resp_t q[$];
    int    idx = 0;
    logic  exp_drop = 1'b0;

    function automatic resp_t mk_alu(input logic [15:0] d);
        resp_t r;
`ifdef TX_FRAME_EN
        r.bytes = {d[15:8], d[7:0], 8'h41};
        r.n     = 8'd3;
`else
        r.bytes = {8'h00, d[15:8], d[7:0]};
        r.n     = 8'd2;
`endif
        return r;
    endfunction

    function automatic resp_t mk_rf(input logic [7:0] d);
        resp_t r;
`ifdef TX_FRAME_EN
        r.bytes = {8'h00, d, 8'h52};
        r.n     = 8'd2;
`else
        r.bytes = {16'h0000, d};
        r.n     = 8'd1;
`endif
        return r;
    endfunction

    always @(posedge CLK) begin : model
        logic dn;
        dn = 1'b0;
        if (!RST) begin
            q.delete();
            idx      = 0;
            exp_drop = 1'b0;
        end else begin
            if (q.size() > 0 && !FIFO_FULL) begin
                idx++;
                if (idx == int'(q[0].n)) begin
                    void'(q.pop_front());
                    idx = 0;
                end
            end
            if (ALU_OUT_VLD) begin
                if (q.size() < 2) q.push_back(mk_alu(ALU_OUT));
                else dn = 1'b1;
            end
            if (RF_RdData_VLD) begin
                if (q.size() < 2) q.push_back(mk_rf(RF_RdData));
                else dn = 1'b1;
            end
            exp_drop = dn;
        end
    end

    always @(negedge CLK) begin : compare
        logic       ei;
        logic [7:0] ed;
        ei = RST && (q.size() > 0) && !FIFO_FULL;
        ed = (RST && q.size() > 0) ? 8'(q[0].bytes >> (8 * idx)) : 8'h00;
        chk("wr_inc", {31'd0, WR_INC}, {31'd0, ei});
        chk("wr_data", {24'd0, WR_DATA}, {24'd0, ed});
        chk("busy", {31'd0, BUSY}, {31'd0, q.size() > 0});
        chk("drop_err", {31'd0, DROP_ERR}, {31'd0, exp_drop});
        if (WR_INC) begin
            log_c.push_back(cyc);
            log_b.push_back(WR_DATA);
        end
        if (DROP_ERR) drops++;
    end

    task automatic cyc1(input logic av, input logic [15:0] a, input logic rv,
                        input logic [7:0] r, input logic full, input logic rst);
        @(posedge CLK);
        #1;
        ALU_OUT_VLD   = av;
        ALU_OUT       = a;
        RF_RdData_VLD = rv;
        RF_RdData     = r;
        FIFO_FULL     = full;
        RST           = rst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b1);
    endtask

    task automatic probe();
        @(negedge CLK);
        #1;
    endtask

    task automatic clr_log();
        log_c.delete();
        log_b.delete();
        drops = 0;
    endtask

    // bytes[7:0] is the first byte expected; written on consecutive cycles from c0
    task automatic chk_log(input string nm, input int n, input logic [63:0] bytes, input int c0);
        chk($sformatf("%s_count", nm), log_b.size(), n);
        for (int i = 0; i < n && i < log_b.size(); i++) begin
            chk($sformatf("%s_byte%0d", nm, i), {24'd0, log_b[i]}, {24'd0, bytes[8*i +: 8]});
            chk($sformatf("%s_cyc%0d", nm, i), log_c[i], c0 + i);
        end
    endtask

    initial begin
        int n;
        cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        probe();
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_wr_inc", {31'd0, WR_INC}, 32'd0);
        chk("rst_wr_data", {24'd0, WR_DATA}, 32'd0);
        chk("rst_drop", {31'd0, DROP_ERR}, 32'd0);
        idle(2);

`ifndef TX_FRAME_EN
        clr_log();
        cyc1(1'b0, 16'h0, 1'b1, 8'h3C, 1'b0, 1'b1);
        n = cyc;
        idle(1);
        probe();
        chk("s1_inc", {31'd0, WR_INC}, 32'd1);
        chk("s1_data", {24'd0, WR_DATA}, 32'h3C);
        chk("s1_busy_n1", {31'd0, BUSY}, 32'd1);
        idle(1);
        probe();
        chk("s1_busy_n2", {31'd0, BUSY}, 32'd0);
        idle(2);
        chk_log("s1", 1, 64'h3C, n + 1);

        clr_log();
        cyc1(1'b1, 16'hBEEF, 1'b0, 8'h0, 1'b0, 1'b1);
        n = cyc;
        cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 1'b1);
        probe();
        chk("s2_stall_data", {24'd0, WR_DATA}, 32'hEF);
        chk("s2_stall_inc", {31'd0, WR_INC}, 32'd0);
        cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 1'b1);
        cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 1'b1);
        probe();
        chk("s2_stall_data3", {24'd0, WR_DATA}, 32'hEF);
        idle(4);
        chk_log("s2", 2, 64'hBEEF, n + 4);

        clr_log();
        cyc1(1'b1, 16'h1234, 1'b1, 8'h77, 1'b0, 1'b1);
        n = cyc;
        idle(5);
        chk_log("s3", 3, 64'h771234, n + 1);
        chk("s3_drops", drops, 0);

        clr_log();
        cyc1(1'b1, 16'h1111, 1'b0, 8'h0, 1'b1, 1'b1);
        n = cyc;
        cyc1(1'b0, 16'h0, 1'b1, 8'h22, 1'b1, 1'b1);
        cyc1(1'b0, 16'h0, 1'b1, 8'h33, 1'b1, 1'b1);
        cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b1, 1'b1);
        probe();
        chk("s4_drop_pulse", {31'd0, DROP_ERR}, 32'd1);
        idle(6);
        chk_log("s4", 3, 64'h221111, n + 4);
        chk("s4_drops", drops, 1);

        clr_log();
        cyc1(1'b1, 16'hABCD, 1'b0, 8'h0, 1'b0, 1'b1);
        n = cyc;
        idle(1);
        cyc1(1'b0, 16'h0, 1'b0, 8'h0, 1'b0, 1'b0);
        probe();
        chk("s5_rst_inc", {31'd0, WR_INC}, 32'd0);
        chk("s5_rst_data", {24'd0, WR_DATA}, 32'd0);
        idle(1);
        probe();
        chk("s5_busy", {31'd0, BUSY}, 32'd0);
        chk("s5_inc", {31'd0, WR_INC}, 32'd0);
        idle(3);
        chk_log("s5", 1, 64'hCD, n + 1);

        clr_log();
        cyc1(1'b1, 16'h5566, 1'b0, 8'h0, 1'b0, 1'b1);
        n = cyc;
        cyc1(1'b0, 16'h0, 1'b1, 8'h99, 1'b0, 1'b1);
        idle(4);
        chk_log("s6", 3, 64'h995566, n + 1);

        clr_log();
        cyc1(1'b0, 16'h0, 1'b1, 8'h01, 1'b0, 1'b1);
        n = cyc;
        cyc1(1'b0, 16'h0, 1'b1, 8'h02, 1'b0, 1'b1);
        idle(3);
        chk_log("s7", 2, 64'h0201, n + 1);

        clr_log();
        cyc1(1'b1, 16'hA1B2, 1'b0, 8'h0, 1'b0, 1'b1);
        n = cyc;
        cyc1(1'b1, 16'hC3D4, 1'b0, 8'h0, 1'b0, 1'b1);
        cyc1(1'b1, 16'hE5F6, 1'b1, 8'h07, 1'b0, 1'b1);
        idle(6);
        chk_log("s8", 6, 64'hE5F6C3D4A1B2, n + 1);
        chk("s8_drops", drops, 1);
`else
        clr_log();
        cyc1(1'b1, 16'h00FF, 1'b0, 8'h0, 1'b0, 1'b1);
        n = cyc;
        idle(5);
        chk_log("f1", 3, 64'h00FF41, n + 1);

        clr_log();
        cyc1(1'b0, 16'h0, 1'b1, 8'h5A, 1'b0, 1'b1);
        n = cyc;
        idle(4);
        chk_log("f2", 2, 64'h5A52, n + 1);

        clr_log();
        cyc1(1'b1, 16'h1234, 1'b1, 8'h77, 1'b0, 1'b1);
        n = cyc;
        idle(7);
        chk_log("f3", 5, 64'h7752123441, n + 1);
        chk("f3_drops", drops, 0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
